// File: rtl/tile_fetch_arbiter.sv
// Round-robin arbiter sharing one tile ROM port between CHANNELS layers.
// Each fetched chunky word is converted to planar form (optionally h-flipped) and held per channel.
module tile_fetch_arbiter #(
   parameter int CHANNELS = 2,
   parameter int AW       = 18,
   parameter int BPP      = 4,
   parameter int PIX      = 8,
   parameter int TIMEOUT  = 15
) (
   input  logic                          clk_main,
   input  logic                          nRES,
   input  logic                          flush,
   input  logic [CHANNELS-1:0]           ch_req,
   input  logic [CHANNELS*AW-1:0]        ch_addr,
   input  logic [CHANNELS-1:0]           ch_flip,
   output logic [CHANNELS-1:0]           ch_busy,
   output logic [CHANNELS-1:0]           ch_valid,
   output logic [CHANNELS-1:0]           ch_err,
   output logic [CHANNELS*BPP*PIX-1:0]   ch_data,
   output logic [AW-1:0]                 rom_addr,
   output logic                          rom_rd,
   input  logic                          rom_valid,
   input  logic [BPP*PIX-1:0]            rom_data
);

   localparam int W  = BPP * PIX;
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t              state;
   logic [CHANNELS-1:0] pend;
   logic [CHANNELS-1:0] pend_next;
   logic [AW-1:0]       pend_addr [CHANNELS];
   logic [CHANNELS-1:0] pend_flip;
   logic [CW-1:0]       grant;
   logic [CW-1:0]       rr;
   logic [CW-1:0]       pick;
   logic [CW-1:0]       grant_inc;
   logic                pick_found;
   logic                cur_flip;
   logic [TW-1:0]       cnt;

   function automatic logic [W-1:0] to_planar(input logic [W-1:0] d, input logic f);
      logic [W-1:0] r;
      r = '0;
      for (int b = 0; b < BPP; b++) begin
         for (int p = 0; p < PIX; p++) begin
            r[b*PIX+p] = f ? d[(PIX-1-p)*BPP+b] : d[p*BPP+b];
         end
      end
      return r;
   endfunction

   // First pending channel at or after the round-robin pointer, wrapping.
   always_comb begin
      pick       = '0;
      pick_found = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (!pick_found && pend[(int'(rr) + i) % CHANNELS]) begin
            pick_found = 1'b1;
            pick       = CW'((int'(rr) + i) % CHANNELS);
         end
      end
   end

   assign grant_inc = (grant == CW'(CHANNELS - 1)) ? '0 : grant + 1'b1;

   // A request arriving on the grant cycle re-arms the channel, so set wins over clear.
   always_comb begin
      pend_next = pend;
      if (state == IDLE && pick_found) begin
         pend_next[pick] = 1'b0;
      end
      pend_next = pend_next | ch_req;
   end

   always_comb begin
      ch_busy = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         ch_busy[c] = pend[c] | ((state != IDLE) && (grant == CW'(c)));
      end
   end

   always_ff @(posedge clk_main or negedge nRES) begin
      if (!nRES) begin
         state     <= IDLE;
         pend      <= '0;
         pend_flip <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            pend_addr[c] <= '0;
         end
         grant     <= '0;
         rr        <= '0;
         cur_flip  <= 1'b0;
         cnt       <= '0;
         rom_addr  <= '0;
         rom_rd    <= 1'b0;
         ch_valid  <= '0;
         ch_err    <= '0;
         ch_data   <= '0;
      end else begin
         rom_rd   <= 1'b0;
         ch_valid <= '0;
         ch_err   <= '0;
         if (flush) begin
            pend  <= '0;
            state <= IDLE;
         end else begin
            pend <= pend_next;
            for (int c = 0; c < CHANNELS; c++) begin
               if (ch_req[c]) begin
                  pend_addr[c] <= ch_addr[c*AW +: AW];
                  pend_flip[c] <= ch_flip[c];
               end
            end
            case (state)
               IDLE: begin
                  if (pick_found) begin
                     grant    <= pick;
                     rom_addr <= pend_addr[pick];
                     cur_flip <= pend_flip[pick];
                     rom_rd   <= 1'b1;
                     state    <= ISSUE;
                  end
               end
               ISSUE: begin
                  cnt   <= '0;
                  state <= WAIT;
               end
               // cnt counts WAIT cycles from 0; TIMEOUT silent WAIT cycles abandon the fetch.
               WAIT: begin
                  if (rom_valid) begin
                     ch_data[grant*W +: W] <= to_planar(rom_data, cur_flip);
                     ch_valid[grant]       <= 1'b1;
                     rr                    <= grant_inc;
                     state                 <= IDLE;
                  end else if (cnt == TW'(TIMEOUT - 1)) begin
                     ch_err[grant] <= 1'b1;
                     rr            <= grant_inc;
                     state         <= IDLE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tile_fetch_arbiter.sv
// Bench for tile_fetch_arbiter: a timeline model predicts every output each cycle,
// and directed scenarios pin key cycles with hand-computed literal values.
module tb_tile_fetch_arbiter;

   localparam int CH  = 2;
   localparam int AW  = 18;
   localparam int BPP = 4;
   localparam int PIX = 8;
   localparam int TO  = 15;
   localparam int W   = BPP * PIX;

   logic              clk_main;
   logic              nRES;
   logic              flush;
   logic [CH-1:0]     ch_req;
   logic [CH*AW-1:0]  ch_addr;
   logic [CH-1:0]     ch_flip;
   logic [CH-1:0]     ch_busy;
   logic [CH-1:0]     ch_valid;
   logic [CH-1:0]     ch_err;
   logic [CH*W-1:0]   ch_data;
   logic [AW-1:0]     rom_addr;
   logic              rom_rd;
   logic              rom_valid;
   logic [W-1:0]      rom_data;

   tile_fetch_arbiter #(
      .CHANNELS(CH), .AW(AW), .BPP(BPP), .PIX(PIX), .TIMEOUT(TO)
   ) dut (
      .clk_main(clk_main), .nRES(nRES), .flush(flush),
      .ch_req(ch_req), .ch_addr(ch_addr), .ch_flip(ch_flip),
      .ch_busy(ch_busy), .ch_valid(ch_valid), .ch_err(ch_err), .ch_data(ch_data),
      .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_valid(rom_valid), .rom_data(rom_data)
   );

   initial begin
      clk_main = 1'b0;
      forever #5 clk_main = ~clk_main;
   end

   // Model: pending set plus one in-flight fetch described by the cycle of its read strobe.
   bit   [CH-1:0] m_pend;
   logic [AW-1:0] m_paddr [CH];
   bit            m_pflip [CH];
   int            m_busy;
   int            m_rd;
   logic [AW-1:0] m_addr;
   bit            m_flip;
   logic [W-1:0]  m_data [CH];
   int            m_rr;
   bit   [CH-1:0] e_valid;
   bit   [CH-1:0] e_err;
   int            cyc;
   int            last_rd;
   int            total;
   int            bad;

   function automatic logic [W-1:0] m_planar(input logic [W-1:0] d, input bit f);
      int pix [PIX];
      int v;
      logic [W-1:0] r;
      r = '0;
      for (int p = 0; p < PIX; p++) pix[p] = int'(d[p*BPP +: BPP]);
      for (int p = 0; p < PIX; p++) begin
         v = f ? pix[PIX-1-p] : pix[p];
         for (int b = 0; b < BPP; b++) r[b*PIX+p] = v[b];
      end
      return r;
   endfunction

   task automatic model_reset();
      m_pend = '0;
      m_busy = -1;
      m_rd   = -100;
      m_addr = '0;
      m_flip = 1'b0;
      m_rr   = 0;
      e_valid = '0;
      e_err   = '0;
      for (int c = 0; c < CH; c++) begin
         m_paddr[c] = '0;
         m_pflip[c] = 1'b0;
         m_data[c]  = '0;
      end
   endtask

   task automatic model_step();
      int g;
      if (!nRES) begin
         model_reset();
      end else begin
         e_valid = '0;
         e_err   = '0;
         if (flush) begin
            m_pend = '0;
            m_busy = -1;
         end else begin
            if (m_busy >= 0) begin
               if (cyc > m_rd) begin
                  if (rom_valid) begin
                     m_data[m_busy]  = m_planar(rom_data, m_flip);
                     e_valid[m_busy] = 1'b1;
                     m_rr   = (m_busy + 1) % CH;
                     m_busy = -1;
                  end else if (cyc == m_rd + TO) begin
                     e_err[m_busy] = 1'b1;
                     m_rr   = (m_busy + 1) % CH;
                     m_busy = -1;
                  end
               end
            end else if (m_pend != '0) begin
               g = -1;
               for (int k = 0; k < CH; k++) begin
                  if (g < 0 && m_pend[(m_rr + k) % CH]) g = (m_rr + k) % CH;
               end
               m_busy    = g;
               m_rd      = cyc + 1;
               m_addr    = m_paddr[g];
               m_flip    = m_pflip[g];
               m_pend[g] = 1'b0;
            end
            for (int c = 0; c < CH; c++) begin
               if (ch_req[c]) begin
                  m_pend[c]  = 1'b1;
                  m_paddr[c] = ch_addr[c*AW +: AW];
                  m_pflip[c] = ch_flip[c];
               end
            end
         end
      end
      cyc++;
   endtask

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic compare_all();
      logic [CH*W-1:0] edata;
      bit   [CH-1:0]   ebusy;
      bit              erd;
      logic [AW-1:0]   eaddr;
      bit   [CH-1:0]   ev;
      bit   [CH-1:0]   ee;
      ebusy = m_pend;
      if (m_busy >= 0) ebusy[m_busy] = 1'b1;
      for (int c = 0; c < CH; c++) edata[c*W +: W] = m_data[c];
      erd   = (m_busy >= 0) && (cyc == m_rd);
      eaddr = m_addr;
      ev    = e_valid;
      ee    = e_err;
      if (!nRES) begin
         edata = '0; ebusy = '0; erd = 1'b0; eaddr = '0; ev = '0; ee = '0;
      end
      check_output("rom_rd",   64'(rom_rd),   64'(erd));
      check_output("rom_addr", 64'(rom_addr), 64'(eaddr));
      check_output("ch_busy",  64'(ch_busy),  64'(ebusy));
      check_output("ch_valid", 64'(ch_valid), 64'(ev));
      check_output("ch_err",   64'(ch_err),   64'(ee));
      check_output("ch_data",  64'(ch_data),  64'(edata));
      if (rom_rd === 1'b1) begin
         check_output("rd_spacing", 64'(cyc - last_rd >= 3), 64'd1);
         last_rd = cyc;
      end
   endtask

   task automatic tick();
      @(negedge clk_main);
      compare_all();
      @(posedge clk_main);
      model_step();
      #2;
   endtask

   task automatic set_req(input int c, input logic [AW-1:0] a, input bit f);
      ch_req[c]           = 1'b1;
      ch_addr[c*AW +: AW] = a;
      ch_flip[c]          = f;
   endtask

   // Request at cycle 0, ROM answers in cycle 2+k; result expected in cycle 3+k.
   task automatic fetch_one(input int c, input logic [AW-1:0] a, input bit f,
                            input logic [W-1:0] d, input int k, input logic [W-1:0] expd);
      set_req(c, a, f);
      tick();
      ch_req = '0;
      tick();
      check_output("fetch_rd",   64'(rom_rd),   64'd1);
      check_output("fetch_addr", 64'(rom_addr), 64'(a));
      repeat (k) tick();
      rom_valid = 1'b1;
      rom_data  = d;
      tick();
      rom_valid = 1'b0;
      check_output("fetch_valid", 64'(ch_valid), 64'(1 << c));
      check_output("fetch_data",  64'(ch_data[c*W +: W]), 64'(expd));
      tick();
   endtask

   task automatic both_round(input int first, input int second);
      logic [AW-1:0] a [CH];
      a[0] = 18'h00100;
      a[1] = 18'h00200;
      ch_req  = 2'b11;
      ch_addr = {a[1], a[0]};
      ch_flip = '0;
      tick();
      ch_req = '0;
      tick();
      check_output("rr_first_rd",   64'(rom_rd),   64'd1);
      check_output("rr_first_addr", 64'(rom_addr), 64'(a[first]));
      tick();
      rom_valid = 1'b1;
      rom_data  = 32'h11111111;
      tick();
      rom_valid = 1'b0;
      check_output("rr_first_valid", 64'(ch_valid), 64'(1 << first));
      check_output("rr_first_data",  64'(ch_data[first*W +: W]), 64'h000000FF);
      tick();
      check_output("rr_second_rd",   64'(rom_rd),   64'd1);
      check_output("rr_second_addr", 64'(rom_addr), 64'(a[second]));
      tick();
      rom_valid = 1'b1;
      rom_data  = 32'h22222222;
      tick();
      rom_valid = 1'b0;
      check_output("rr_second_valid", 64'(ch_valid), 64'(1 << second));
      check_output("rr_second_data",  64'(ch_data[second*W +: W]), 64'h0000FF00);
      tick();
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0; last_rd = -10;
      model_reset();
      nRES = 1'b0; flush = 1'b0; ch_req = '0; ch_addr = '0; ch_flip = '0;
      rom_valid = 1'b0; rom_data = '0;
      @(posedge clk_main);
      model_step();
      #2;
      repeat (2) tick();
      check_output("reset_busy", 64'(ch_busy), 64'd0);
      check_output("reset_rd",   64'(rom_rd),  64'd0);
      check_output("reset_data", 64'(ch_data), 64'd0);
      nRES = 1'b1;
      repeat (2) tick();

      // Basic conversion, plain and flipped
      fetch_one(0, 18'h12345, 1'b0, 32'h76543210, 2, 32'h00F0CCAA);
      fetch_one(0, 18'h12345, 1'b1, 32'h76543210, 2, 32'h000F3355);

      // Round robin: bring pointer to 0, then both; then pointer to 1, then both
      fetch_one(1, 18'h01000, 1'b0, 32'hFFFFFFFF, 1, 32'hFFFFFFFF);
      both_round(0, 1);
      fetch_one(0, 18'h02000, 1'b1, 32'h00000000, 1, 32'h00000000);
      both_round(1, 0);

      // Timeout on ch1, then a fresh fetch completes
      set_req(1, 18'h3ABCD, 1'b0);
      tick();
      ch_req = '0;
      tick();
      check_output("to_rd", 64'(rom_rd), 64'd1);
      repeat (15) tick();
      check_output("to_early_err", 64'(ch_err), 64'd0);
      tick();
      check_output("to_err",  64'(ch_err),  64'h2);
      check_output("to_busy", 64'(ch_busy), 64'd0);
      check_output("to_data", 64'(ch_data[W +: W]), 64'h000000FF);
      tick();
      fetch_one(1, 18'h0AAAA, 1'b0, 32'h89ABCDEF, 3, 32'hFF0F3355);

      // Flush during WAIT drops in-flight, pending and same-cycle requests
      set_req(1, 18'h01111, 1'b0);
      tick();
      ch_req = '0;
      tick();
      tick();
      set_req(0, 18'h05555, 1'b0);
      tick();
      ch_req = '0;
      flush  = 1'b1;
      set_req(0, 18'h06666, 1'b0);
      tick();
      flush     = 1'b0;
      ch_req    = '0;
      rom_valid = 1'b1;
      rom_data  = 32'h12345678;
      tick();
      rom_valid = 1'b0;
      check_output("flush_valid", 64'(ch_valid), 64'd0);
      check_output("flush_busy",  64'(ch_busy),  64'd0);
      repeat (5) tick();

      // Last address wins before grant; async reset in WAIT
      set_req(1, 18'h07777, 1'b0);
      tick();
      ch_req = '0;
      set_req(0, 18'h11111, 1'b0);
      tick();
      ch_req = '0;
      check_output("lw_rd1_addr", 64'(rom_addr), 64'h07777);
      tick();
      set_req(0, 18'h22222, 1'b0);
      tick();
      ch_req    = '0;
      rom_valid = 1'b1;
      rom_data  = 32'h0;
      tick();
      rom_valid = 1'b0;
      tick();
      check_output("lw_rd2",      64'(rom_rd),   64'd1);
      check_output("lw_rd2_addr", 64'(rom_addr), 64'h22222);
      tick();
      tick();
      nRES      = 1'b0;
      rom_valid = 1'b1;
      #1;
      check_output("rst_rd",    64'(rom_rd),   64'd0);
      check_output("rst_addr",  64'(rom_addr), 64'd0);
      check_output("rst_busy",  64'(ch_busy),  64'd0);
      check_output("rst_valid", 64'(ch_valid), 64'd0);
      check_output("rst_err",   64'(ch_err),   64'd0);
      check_output("rst_data",  64'(ch_data),  64'd0);
      tick();
      tick();
      nRES = 1'b1;
      tick();
      rom_valid = 1'b0;
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
